// File: rtl/modulo_escalonador_rolhas.sv
// -----------------------------------------------------------------------------
// modulo_escalonador_rolhas
// Sequencer/arbiter for the two cork buffers. It owns the secondary buffer
// (operator bulk loads, ceiling MAX_SEC) and the main buffer that feeds the
// sealing station. The single secondary-buffer count path is shared between
// operator loads (one cork per cycle) and automatic refills (TRANSFER corks
// moved one per cycle from secondary to main). Refill always wins arbitration.
// Single-cork seal requests are serviced in every state.
//
// Ports:
//   clk_i           system clock
//   reset_i         synchronous active-high reset
//   op_load_req_i   operator load request (level, held until ack/rej)
//   op_load_qty_i   corks to add, stable while the request is held
//   op_load_ack_o   one-cycle pulse: load completed
//   op_load_rej_o   one-cycle pulse: load refused (would exceed MAX_SEC)
//   seal_req_i      one-cycle pulse: consume one cork from main
//   seal_ack_o      one-cycle pulse: cork granted
//   seal_nak_o      one-cycle pulse: main buffer empty
//   sec_count_o     secondary buffer contents
//   main_count_o    main buffer contents
//   ro_o            main buffer empty
//   refill_done_o   one-cycle pulse at end of refill
//   busy_o          sequencer not idle
//   state_o         IDLE=00, LOAD=01, REFILL=10
// -----------------------------------------------------------------------------
module modulo_escalonador_rolhas #(
    parameter int unsigned MAX_SEC   = 99,
    parameter int unsigned INIT_MAIN = 20,
    parameter int unsigned MIN_MAIN  = 5,
    parameter int unsigned TRANSFER  = 20
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       op_load_req_i,
    input  logic [6:0] op_load_qty_i,
    output logic       op_load_ack_o,
    output logic       op_load_rej_o,
    input  logic       seal_req_i,
    output logic       seal_ack_o,
    output logic       seal_nak_o,
    output logic [6:0] sec_count_o,
    output logic [4:0] main_count_o,
    output logic       ro_o,
    output logic       refill_done_o,
    output logic       busy_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_REFILL = 2'b10
    } state_t;

    localparam logic [6:0] MAX_SEC_C   = 7'(MAX_SEC);
    localparam logic [4:0] INIT_MAIN_C = 5'(INIT_MAIN);
    localparam logic [4:0] MIN_MAIN_C  = 5'(MIN_MAIN);
    localparam logic [6:0] TRANSFER_C  = 7'(TRANSFER);

    state_t     state_q, state_d;
    logic [6:0] sec_q, sec_d;
    logic [4:0] main_q, main_d;
    logic [6:0] rem_q, rem_d;
    logic       ack_q, ack_d;
    logic       rej_q, rej_d;
    logic       sack_q, sack_d;
    logic       snak_q, snak_d;
    logic       done_q, done_d;

    logic       refill_want_s;
    logic       op_pending_s;
    logic [7:0] load_sum_s;
    logic       load_over_s;
    logic       load_zero_s;
    logic       last_step_s;
    logic       seal_take_s;
    logic       main_inc_s;

    // Arbitration and step qualifiers, all derived from registered state
    assign refill_want_s = (main_q < MIN_MAIN_C) && (sec_q >= TRANSFER_C);
    // The ack/rej pulse cycle still sees the held request; masking it avoids re-serving it
    assign op_pending_s  = op_load_req_i && !ack_q && !rej_q;
    // 8-bit sum so that 7-bit overflow cannot hide an over-ceiling load
    assign load_sum_s    = {1'b0, sec_q} + {1'b0, op_load_qty_i};
    assign load_over_s   = load_sum_s > {1'b0, MAX_SEC_C};
    assign load_zero_s   = (op_load_qty_i == 7'd0);
    assign last_step_s   = (rem_q <= 7'd1);
    assign seal_take_s   = seal_req_i && (main_q != 5'd0);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            sec_q   <= 7'd0;
            main_q  <= INIT_MAIN_C;
            rem_q   <= 7'd0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            sack_q  <= 1'b0;
            snak_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            main_q  <= main_d;
            rem_q   <= rem_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
            sack_q  <= sack_d;
            snak_q  <= snak_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: refill has priority over operator loads in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (refill_want_s) begin
                    state_d = ST_REFILL;
                end else if (op_pending_s && !load_over_s && !load_zero_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_step_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_REFILL: begin
                if (last_step_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Buffer counters, step counter and response pulses
    always_comb begin
        sec_d      = sec_q;
        rem_d      = rem_q;
        ack_d      = 1'b0;
        rej_d      = 1'b0;
        done_d     = 1'b0;
        main_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (refill_want_s) begin
                    rem_d = TRANSFER_C;
                end else if (op_pending_s) begin
                    if (load_over_s) begin
                        rej_d = 1'b1;
                    end else if (load_zero_s) begin
                        ack_d = 1'b1;
                    end else begin
                        rem_d = op_load_qty_i;
                    end
                end else begin
                    rem_d = rem_q;
                end
            end
            ST_LOAD: begin
                sec_d = sec_q + 7'd1;
                rem_d = rem_q - 7'd1;
                if (last_step_s) begin
                    ack_d = 1'b1;
                end else begin
                    ack_d = 1'b0;
                end
            end
            ST_REFILL: begin
                sec_d      = sec_q - 7'd1;
                rem_d      = rem_q - 7'd1;
                main_inc_s = 1'b1;
                if (last_step_s) begin
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: rem_d = 7'd0;
        endcase

        // Seal is judged on the registered main count; a refill step plus a
        // granted cork cancel out
        sack_d = seal_take_s;
        snak_d = seal_req_i && (main_q == 5'd0);
        case ({main_inc_s, seal_take_s})
            2'b10:   main_d = main_q + 5'd1;
            2'b01:   main_d = main_q - 5'd1;
            default: main_d = main_q;
        endcase
    end

    // Outputs: pulses and counts come straight from registers
    always_comb begin
        op_load_ack_o = ack_q;
        op_load_rej_o = rej_q;
        seal_ack_o    = sack_q;
        seal_nak_o    = snak_q;
        refill_done_o = done_q;
        sec_count_o   = sec_q;
        main_count_o  = main_q;
        ro_o          = (main_q == 5'd0);
        busy_o        = (state_q != ST_IDLE);
        state_o       = state_q;
    end

endmodule

// File: doc/modulo_escalonador_rolhas.md
Name: modulo_escalonador_rolhas

Overview:
- Sequencer and arbiter for the two cork buffers: the secondary buffer (7-bit, max 99) and the main buffer (5-bit) feeding the sealing station.
- Shares the single secondary-buffer count path between two requesters: the operator bulk load (adds corks) and the automatic refill (moves a fixed batch from secondary to main when main is low).
- Also services one-cork consumption requests from the sealing FSM.
- Owns both buffer registers; display encoders and the enchimento/vedação FSM read its outputs.

Parameters:
- MAX_SEC, 99, secondary buffer ceiling.
- INIT_MAIN, 20, main buffer value after reset.
- MIN_MAIN, 5, refill triggers when main_count < MIN_MAIN.
- TRANSFER, 20, corks moved per refill. Constraint: MIN_MAIN-1+TRANSFER <= 31.

Ports:
- clk  in  1  system clock (divided clock domain)
- reset  in  1  synchronous, active-high reset
- op_load_req  in  1  operator load request; level, held until ack or rej
- op_load_qty  in  7  corks to add; stable while op_load_req=1
- op_load_ack  out  1  one-cycle pulse: load completed
- op_load_rej  out  1  one-cycle pulse: load refused (would exceed MAX_SEC)
- seal_req  in  1  one-cycle pulse: sealing consumes one cork from main
- seal_ack  out  1  one-cycle pulse: cork granted
- seal_nak  out  1  one-cycle pulse: no cork available
- sec_count  out  7  secondary buffer contents
- main_count  out  5  main buffer contents
- ro  out  1  main_count==0 (combinational from register)
- refill_done  out  1  one-cycle pulse at end of refill
- busy  out  1  state != IDLE
- state  out  2  IDLE=00, LOAD=01, REFILL=10; 11 unused

Behaviour:
- Reset values: state=IDLE, sec_count=0, main_count=INIT_MAIN, all pulse outputs=0, remaining=0.
- IDLE arbitration, in priority order:
  - (1) refill: main_count<MIN_MAIN and sec_count>=TRANSFER. Next state REFILL, remaining=TRANSFER.
  - (2) operator: op_load_req=1 and op_load_ack=0 and op_load_rej=0.
    - If sec_count+op_load_qty > MAX_SEC (8-bit sum): op_load_rej=1 next cycle, stay IDLE.
    - Else if qty==0: op_load_ack=1 next cycle, stay IDLE.
    - Else: next state LOAD, remaining=qty.
- A pending operator request waits while refill has priority or busy=1. It is never dropped.
- LOAD: each cycle sec_count+1 and remaining-1. When remaining reaches 0: state=IDLE and op_load_ack=1 in that IDLE cycle. Total duration is qty cycles.
- REFILL: each cycle sec_count-1, main_count+1, remaining-1. On the last step: state=IDLE and refill_done=1. Total duration is TRANSFER cycles.
- Seal, serviced in every state and evaluated on the registered main_count:
  - If main_count>0: decrement at this edge and seal_ack=1 next cycle.
  - Else: seal_nak=1 next cycle, no change.
  - Seal during a REFILL step: net main change is 0, ack still issued.
  - seal_req with main_count==0 during REFILL is still nak'd.
- No wrap: sec_count never exceeds MAX_SEC (guaranteed by the reject check) and never goes below 0 (guaranteed by the refill precondition).
- Refill re-arms only from IDLE. If main is still below MIN_MAIN after refill and sec_count>=TRANSFER, a new refill starts on the next IDLE cycle.
- If sec_count<TRANSFER with main low: no refill, IDLE continues to serve the operator.
- Illegal state 11 goes to IDLE next cycle; counts are unchanged.
- Reset mid-LOAD or mid-REFILL: abort immediately to reset values. No ack or done is issued.
- reset has priority over all requests in the same cycle.

Test Plan:
- Reset, then op_load_req=1 with qty=30 -> busy for 30 cycles, sec_count steps 0→30, op_load_ack one pulse, main_count stays 20.
- sec_count=90, request qty=15 -> op_load_rej pulse next cycle, sec_count=90, state stays IDLE. Then qty=9 -> ack, sec_count=99.
- main_count=20, sec_count=40, pulse seal_req 16 times -> main_count=4. REFILL starts next cycle and runs 20 cycles, ending at sec_count=20, main_count=24, with a refill_done pulse.
- During REFILL, op_load_req=1 qty=5 and one seal_req -> seal_ack, main net unchanged that cycle. Load starts only after refill_done and ends at sec_count=25, with ack.
- main_count=0 and sec_count=10: seal_req -> seal_nak, ro=1, no refill started. Operator loads 10 -> sec_count=20, then refill starts automatically.
- Assert reset at cycle 7 of a qty=30 LOAD -> next cycle sec_count=0, main_count=20, IDLE, no op_load_ack pulse.
